// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the buffered 1-to-2 stream demultiplexer.
// Channel tag encoding matches the 2:1 select mux (1 -> a, 0 -> b).
package stream_demux_pkg;

  typedef enum logic {
    CH_B = 1'b0,
    CH_A = 1'b1
  } ch_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel circular FIFO with occupancy count.
// Head data reads as zero whenever the FIFO is empty.
module stream_fifo
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  output logic                            full,
  input  logic                            pop,
  output logic [WIDTH-1:0]                head_data,
  output logic                            empty,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_en;
  logic             rd_en;

  // Guard both ports so a misbehaving caller cannot corrupt the count.
  always_comb begin
    full      = (cnt == CW'(DEPTH));
    empty     = (cnt == '0);
    wr_en     = push && !full;
    rd_en     = pop && !empty;
    count     = cnt;
    head_data = empty ? '0 : mem[rd_ptr];
  end

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is left unreset; stale entries are hidden by the count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// Buffered 1-to-2 stream demux: in_sel steers each beat into FIFO a or b.
// in_ready depends only on in_sel and registered fullness.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              a_data,
  output logic                          a_valid,
  input  logic                          a_ready,
  output logic [count_width(DEPTH)-1:0] a_count,
  output logic [WIDTH-1:0]              b_data,
  output logic                          b_valid,
  input  logic                          b_ready,
  output logic [count_width(DEPTH)-1:0] b_count
);

  ch_e  sel;
  logic a_full;
  logic b_full;
  logic a_empty;
  logic b_empty;
  logic a_push;
  logic b_push;
  logic a_pop;
  logic b_pop;

  assign sel = ch_e'(in_sel);

  // Ready mux and steering; a beat goes to exactly one FIFO.
  always_comb begin
    in_ready = 1'b0;
    a_push   = 1'b0;
    b_push   = 1'b0;
    unique case (sel)
      CH_A: begin
        in_ready = !a_full;
        a_push   = in_valid && !a_full;
      end
      CH_B: begin
        in_ready = !b_full;
        b_push   = in_valid && !b_full;
      end
      default: ;
    endcase
  end

  // Output handshakes: a channel pops only its own head.
  always_comb begin
    a_valid = !a_empty;
    b_valid = !b_empty;
    a_pop   = a_valid && a_ready;
    b_pop   = b_valid && b_ready;
  end

  stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push),
    .push_data (in_data),
    .full      (a_full),
    .pop       (a_pop),
    .head_data (a_data),
    .empty     (a_empty),
    .count     (a_count)
  );

  stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_push),
    .push_data (in_data),
    .full      (b_full),
    .pop       (b_pop),
    .head_data (b_data),
    .empty     (b_empty),
    .count     (b_count)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed self-checking bench for stream_demux_1to2 (WIDTH=8, DEPTH=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_stream_demux_1to2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [2:0] a_count;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [2:0] b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_count  (a_count),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_count  (b_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_ready = 1'b0;
    b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom);
      in_sel   = 1'($urandom);
      in_data  = 8'($urandom);
      a_ready  = 1'($urandom);
      b_ready  = 1'($urandom);
      step();
    end
    in_sel = 1'b1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got a=%b b=%b exp 0 0", a_valid, b_valid);
    end
    checks++;
    if (a_count !== 3'd0 || b_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got a=%0d b=%0d exp 0 0", a_count, b_count);
    end
    checks++;
    if (a_data !== 8'h00 || b_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got a=%h b=%h exp 00 00", a_data, b_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    idle();
    a_ready = 1'b0;
    b_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_routing();
    a_ready = 1'b1;
    b_ready = 1'b1;
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 8'h11;
    #1;
    checks++;
    if (in_ready !== 1'b1 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_pre got rdy=%b av=%b exp 1 0", in_ready, a_valid);
    end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h11) begin
      errors++;
      $display("FAIL route_a got v=%b d=%h exp 1 11", a_valid, a_data);
    end
    checks++;
    if (b_valid !== 1'b0 || b_data !== 8'h00) begin
      errors++;
      $display("FAIL route_a_leak got bv=%b bd=%h exp 0 00", b_valid, b_data);
    end
    in_sel = 1'b0;
    in_data = 8'h22;
    step();
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h22) begin
      errors++;
      $display("FAIL route_b got v=%b d=%h exp 1 22", b_valid, b_data);
    end
    checks++;
    if (a_valid !== 1'b0 || a_count !== 3'd0) begin
      errors++;
      $display("FAIL route_b_leak got av=%b ac=%0d exp 0 0", a_valid, a_count);
    end
    idle();
    step();
    checks++;
    if (b_valid !== 1'b0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_drain got av=%b bv=%b exp 0 0", a_valid, b_valid);
    end
  endtask

  task automatic fill_a();
    a_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i);
      step();
    end
  endtask

  task automatic test_isolation_full();
    b_ready = 1'b0;
    fill_a();
    in_data = 8'hA4;
    #1;
    checks++;
    if (a_count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL iso_full got cnt=%0d rdy=%b exp 4 0", a_count, in_ready);
    end
    step();
    checks++;
    if (a_count !== 3'd4 || a_data !== 8'hA0) begin
      errors++;
      $display("FAIL iso_refuse got cnt=%0d d=%h exp 4 a0", a_count, a_data);
    end
    in_sel = 1'b0;
    in_data = 8'h55;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL iso_b_ready got %b exp 1", in_ready);
    end
    step();
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h55 || b_count !== 3'd1) begin
      errors++;
      $display("FAIL iso_b got v=%b d=%h c=%0d exp 1 55 1",
               b_valid, b_data, b_count);
    end
    idle();
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    checks++;
    if (b_count !== 3'd0 || a_count !== 3'd4) begin
      errors++;
      $display("FAIL iso_after got b=%0d a=%0d exp 0 4", b_count, a_count);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'hA1;
    exp_q[1] = 8'hA2;
    exp_q[2] = 8'hA3;
    exp_q[3] = 8'hA4;
    a_ready = 1'b1;
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 8'hA4;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fpop_ready got %b exp 0", in_ready);
    end
    step();
    checks++;
    if (a_count !== 3'd3 || a_data !== 8'hA1) begin
      errors++;
      $display("FAIL fpop_first got c=%0d d=%h exp 3 a1", a_count, a_data);
    end
    a_ready = 1'b0;
    step();
    checks++;
    if (a_count !== 3'd4 || a_data !== 8'hA1) begin
      errors++;
      $display("FAIL fpop_push got c=%0d d=%h exp 4 a1", a_count, a_data);
    end
    idle();
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_valid !== 1'b1 || a_data !== exp_q[i]) begin
        errors++;
        $display("FAIL fpop_order[%0d] got v=%b d=%h exp 1 %h",
                 i, a_valid, a_data, exp_q[i]);
      end
      step();
    end
    checks++;
    if (a_count !== 3'd0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL fpop_empty got c=%0d v=%b exp 0 0", a_count, a_valid);
    end
  endtask

  task automatic test_streaming();
    b_ready = 1'b1;
    in_valid = 1'b1;
    in_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'hB0 + 8'(i);
      #0;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready);
      end
      step();
      checks++;
      if (b_valid !== 1'b1 || b_data !== 8'hB0 + 8'(i) || b_count > 3'd1) begin
        errors++;
        $display("FAIL stream_out[%0d] got v=%b d=%h c=%0d exp 1 %h <=1",
                 i, b_valid, b_data, b_count, 8'hB0 + 8'(i));
      end
    end
    idle();
    step();
    checks++;
    if (b_valid !== 1'b0 || b_count !== 3'd0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got bv=%b bc=%0d av=%b exp 0 0 0",
               b_valid, b_count, a_valid);
    end
    b_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    a_ready = 1'b0;
    b_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 8'hC0;
    step();
    in_data = 8'hC1;
    step();
    in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hD0 + 8'(i);
      step();
    end
    idle();
    checks++;
    if (a_count !== 3'd2 || b_count !== 3'd3) begin
      errors++;
      $display("FAIL mrst_pre got a=%0d b=%0d exp 2 3", a_count, b_count);
    end
    #2;
    rst = 1'b1;
    #1;
    in_sel = 1'b1;
    #0;
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0 ||
        a_count !== 3'd0 || b_count !== 3'd0) begin
      errors++;
      $display("FAIL mrst_async got av=%b bv=%b ac=%0d bc=%0d exp 0 0 0 0",
               a_valid, b_valid, a_count, b_count);
    end
    checks++;
    if (a_data !== 8'h00 || b_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mrst_data got ad=%h bd=%h rdy=%b exp 00 00 1",
               a_data, b_data, in_ready);
    end
    step();
    rst = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    step();
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL mrst_stale got av=%b bv=%b exp 0 0", a_valid, b_valid);
    end
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 8'h7E;
    step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h7E || a_count !== 3'd1 ||
        b_valid !== 1'b0) begin
      errors++;
      $display("FAIL mrst_fresh got av=%b ad=%h ac=%0d bv=%b exp 1 7e 1 0",
               a_valid, a_data, a_count, b_valid);
    end
    idle();
    step();
    checks++;
    if (a_valid !== 1'b0 || a_count !== 3'd0) begin
      errors++;
      $display("FAIL mrst_alone got av=%b ac=%0d exp 0 0", a_valid, a_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_routing();
    test_isolation_full();
    test_full_pop();
    test_streaming();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
# stream_demux_1to2

Buffered 1-to-2 stream demultiplexer, the receive-side counterpart of the 2:1 select mux: a single tagged input stream is steered by a per-beat select bit into one of two independent output channels. Each channel has a small FIFO, so a stalled consumer on one channel does not block the other channel until its own FIFO fills. Sits at the far end of a shared link, splitting one time-shared datapath back into channel `a` and channel `b`.

## Interface
- `WIDTH`, 8: data width in bits (≥1).
- `DEPTH`, 4: per-channel FIFO depth; power of two, ≥2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  input beat payload.
- `in_sel`  in  1  routing tag: 1 → channel `a`, 0 → channel `b` (same polarity as the mux, where `x = sel ? a : b`).
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  the FIFO selected by `in_sel` can accept the beat.
- `a_data` / `b_data`  out  WIDTH  head-of-FIFO payload; 0 when the matching valid is low.
- `a_valid` / `b_valid`  out  1  channel FIFO is non-empty.
- `a_ready` / `b_ready`  in  1  consumer accepts the head beat.
- `a_count` / `b_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Input accept: `in_valid && in_ready`. The beat is written to FIFO `a` if `in_sel`=1, otherwise to FIFO `b`. It is never written to both.
- `in_ready` = NOT full(selected FIFO). It depends only on `in_sel` and registered state, never on `a_ready` or `b_ready`.
- Output pop: `x_valid && x_ready` on either channel removes that channel's head beat.
- Per-channel order is preserved. There is no ordering guarantee between channels.
- FIFOs use circular read/write pointers with wrap-around at DEPTH. Occupancy is tracked in a count register of width $clog2(DEPTH)+1.
- Push and pop on the same channel in the same cycle: the count is unchanged, both pointers advance, and the head updates to the next beat.
- A full channel with its consumer popping in the same cycle still refuses the push (no combinational ready pass-through). The push is accepted the following cycle.
- `in_valid` low: `in_sel` and `in_data` are don't-care, and no state changes.
- Reset (async assert, any time): pointers and counts go to 0, `a_valid`/`b_valid` go to 0, data outputs go to 0, and `in_ready` goes to 1. Any buffered beats are discarded and never appear after reset. FIFO storage itself is not reset.

## Timing
- Latency: a beat accepted at edge N appears on `x_valid`/`x_data` after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: 1 beat/cycle in; up to 1 beat/cycle out per channel when that channel keeps up.
- Outputs `x_valid`, `x_data` and `x_count` are registered-state-derived (no input-to-output combinational path).
- `in_ready` is combinational from `in_sel` only.
- Reset deassertion: the first accept is possible at the first rising edge after `rst` falls.

## Structure
- Package `stream_demux_pkg`:
  - `typedef enum logic {CH_B = 1'b0, CH_A = 1'b1} ch_e`
  - localparam helper for count width, `$clog2(DEPTH)+1`.
- Sub-module `stream_fifo` (parameters `WIDTH`, `DEPTH`; ports: push, push_data, full, pop, head_data, empty, count), instantiated twice.
- Top level holds only the steering logic and the `in_ready` mux.

## Test plan
- Reset: hold `rst`=1 with random inputs → `a_valid`=`b_valid`=0, `a_count`=`b_count`=0, `a_data`=`b_data`=0, `in_ready`=1.
- Routing (ready=1 on both channels):
  - push 0x11 with `in_sel`=1, then 0x22 with `in_sel`=0 → `a_data`=0x11 valid exactly one cycle after its accept, then `b_data`=0x22 one cycle after its accept;
  - neither beat ever appears on the other channel.
- Isolation/full (`a_ready`=0):
  - push 0xA0..0xA3 with `in_sel`=1 → `a_count`=4, `in_ready`=0 while `in_sel`=1;
  - switch `in_sel`=0 and push 0x55 → `in_ready`=1 and the beat is accepted, `b_data`=0x55.
- Full with simultaneous pop: channel `a` full, `a_ready`=1, `in_valid`=1, `in_sel`=1 → no push that cycle, `a_count`=3 next; push accepted next cycle, `a_count` back to 4; output order 0xA0, 0xA1, … unchanged.
- Wrap-around/streaming: push 0xB0..0xB9 on `b` with `b_ready`=1 every cycle → steady 1 beat/cycle, `b_count` ≤1, outputs exactly 0xB0..0xB9 in order across pointer wrap.
- Mid-operation reset: `a_count`=2, `b_count`=3 → assert `rst` asynchronously between edges; valids and counts drop immediately; after release, the buffered beats never reappear and a fresh push 0x7E emerges alone.
